multiplicador_seq_param: RTL

//  Parametrised sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one iteration per clock.

---
 rtl/multiplicador_seq_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/multiplicador_seq_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one iteration per clock.
// Define MULT_SIGNED_EN to add the Sinal port and the two's-complement mode.
module multiplicador_seq_param #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               Clk,
   input  logic               reset,
   input  logic               St,
   input  logic [WIDTH-1:0]   Multiplicando,
   input  logic [WIDTH-1:0]   Multiplicador,
`ifdef MULT_SIGNED_EN
   input  logic               Sinal,
`endif
   output logic               Idle,
   output logic               Done,
   output logic [2*WIDTH-1:0] Produto
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 idle_q, idle_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     upper_s;
   logic [WIDTH:0]       sum_s;
   logic                 m_s;
   logic                 last_s;

`ifdef MULT_SIGNED_EN
   logic                 sgn_q, sgn_d;
   logic [WIDTH:0]       ext_u_s;
   logic [WIDTH:0]       ext_m_s;
`endif

   // One add/subtract step on the upper half, selected by the current multiplier LSB
   always_comb begin
      upper_s = acc_q[2*WIDTH-1:WIDTH];
      m_s     = acc_q[0];
      last_s  = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULT_SIGNED_EN
      ext_u_s = {sgn_q & upper_s[WIDTH-1], upper_s};
      ext_m_s = {sgn_q & mcand_q[WIDTH-1], mcand_q};
      // The multiplier MSB carries negative weight, hence the final subtract
      if (!m_s) begin
         sum_s = ext_u_s;
      end else if (sgn_q && last_s) begin
         sum_s = ext_u_s - ext_m_s;
      end else begin
         sum_s = ext_u_s + ext_m_s;
      end
`else
      if (m_s) begin
         sum_s = {1'b0, upper_s} + {1'b0, mcand_q};
      end else begin
         sum_s = {1'b0, upper_s};
      end
`endif
   end

   // Next-state and datapath update for IDLE -> RUN -> DONE -> IDLE
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
`ifdef MULT_SIGNED_EN
      sgn_d   = sgn_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (St) begin
               acc_d   = {{WIDTH{1'b0}}, Multiplicador};
               mcand_d = Multiplicando;
               cnt_d   = {CNT_W{1'b0}};
`ifdef MULT_SIGNED_EN
               sgn_d   = Sinal;
`endif
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            // Carry (or replicated sign) lands in the product MSB via sum_s[WIDTH]
            acc_d = {sum_s, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (last_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      idle_d = (state_d == S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State, datapath and registered handshake flops
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         acc_q   <= {(2*WIDTH){1'b0}};
         mcand_q <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         idle_q  <= 1'b1;
         done_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
         sgn_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         done_q  <= done_d;
`ifdef MULT_SIGNED_EN
         sgn_q   <= sgn_d;
`endif
      end
   end

   assign Idle    = idle_q;
   assign Done    = done_q;
   assign Produto = acc_q;

endmodule
